// File: rtl/thr_window_tracker.sv
`default_nettype none
// ============================================================================
// Module   : thr_window_tracker
// Purpose  : Windowed signed min/max tracker; publishes {max,min} atomically.
// Revision : 1.0
// ============================================================================
module thr_window_tracker #(
  parameter int WINDOW_LOG2 = 10
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        clear_i,
  input  logic [15:0] sample_i,
  input  logic        sample_valid_i,
  output logic [31:0] thresholds_o,
  output logic        valid_o,
  output logic        window_done_o,
  output logic        busy_o
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  localparam logic signed [15:0] c_MIN_START = 16'sh7FFF;
  localparam logic signed [15:0] c_MAX_START = 16'sh8000;

  state_t                   r_state, w_state_nxt;
  logic [WINDOW_LOG2-1:0]   r_count, w_count_nxt;
  logic signed [15:0]       r_min, w_min_nxt;
  logic signed [15:0]       r_max, w_max_nxt;
  logic [31:0]              r_thr, w_thr_nxt;
  logic                     r_valid, w_valid_nxt;
  logic                     r_done, w_done_nxt;
  logic                     r_busy;

  logic signed [15:0]       w_sample;
  logic signed [15:0]       w_min_upd;
  logic signed [15:0]       w_max_upd;
  logic                     w_accept;
  logic                     w_final;

  assign w_sample  = $signed(sample_i);
  assign w_min_upd = (w_sample < r_min) ? w_sample : r_min;
  assign w_max_upd = (w_sample > r_max) ? w_sample : r_max;
  assign w_accept  = (r_state == S_ACCUM) && enable_i && sample_valid_i;
  assign w_final   = w_accept && (r_count == {WINDOW_LOG2{1'b1}});

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_min   <= c_MIN_START;
      r_max   <= c_MAX_START;
      r_thr   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_min   <= w_min_nxt;
      r_max   <= w_max_nxt;
      r_thr   <= w_thr_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt == S_ACCUM);
    end
  end

  // Branch order encodes priority: clear, disable, IDLE entry, publish, accumulate.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_min_nxt   = r_min;
    w_max_nxt   = r_max;
    w_thr_nxt   = r_thr;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;

    if (clear_i) begin
      w_thr_nxt   = '0;
      w_valid_nxt = 1'b0;
      w_count_nxt = '0;
      w_min_nxt   = c_MIN_START;
      w_max_nxt   = c_MAX_START;
      w_state_nxt = enable_i ? S_ACCUM : S_IDLE;
    end else if (!enable_i) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = '0;
      w_min_nxt   = c_MIN_START;
      w_max_nxt   = c_MAX_START;
    end else if (r_state == S_IDLE) begin
      w_state_nxt = S_ACCUM;
      w_count_nxt = '0;
      w_min_nxt   = c_MIN_START;
      w_max_nxt   = c_MAX_START;
    end else if (w_final) begin
      w_thr_nxt   = {w_max_upd, w_min_upd};
      w_valid_nxt = 1'b1;
      w_done_nxt  = 1'b1;
      w_count_nxt = '0;
      w_min_nxt   = c_MIN_START;
      w_max_nxt   = c_MAX_START;
    end else if (w_accept) begin
      w_count_nxt = r_count + 1'b1;
      w_min_nxt   = w_min_upd;
      w_max_nxt   = w_max_upd;
    end
  end

  assign thresholds_o  = r_thr;
  assign valid_o       = r_valid;
  assign window_done_o = r_done;
  assign busy_o        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_thr_window_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_thr_window_tracker
// Purpose  : Directed stimulus with a publish scoreboard for thr_window_tracker.
// Revision : 1.0
// ============================================================================
module tb_thr_window_tracker;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [15:0] sample_i = '0;
  logic        sample_valid_i = 1'b0;
  logic [31:0] thresholds_o;
  logic        valid_o;
  logic        window_done_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [31:0] exp_q[$];

  thr_window_tracker #(.WINDOW_LOG2(2)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .enable_i       (enable_i),
    .clear_i        (clear_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .thresholds_o   (thresholds_o),
    .valid_o        (valid_o),
    .window_done_o  (window_done_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then return just after the capturing edge.
  task automatic step(input logic en, input logic v, input logic [15:0] s, input logic clr);
    enable_i       = en;
    sample_valid_i = v;
    sample_i       = s;
    clear_i        = clr;
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every publish pulse pops the oldest expected thresholds word.
  always @(negedge clk_i) begin
    if (rst_n_i && window_done_o) begin
      pulses++;
      if (exp_q.size() == 0) begin
        chk("unexpected_publish", thresholds_o, 32'hDEAD_BEEF);
      end else begin
        chk("publish_thresholds", thresholds_o, exp_q.pop_front());
        chk("publish_valid", {31'd0, valid_o}, 32'd1);
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("reset_thr", thresholds_o, 32'h0);
    chk("reset_flags", {29'd0, valid_o, window_done_o, busy_o}, 32'h0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    // Idle with valid samples: nothing happens
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'(i * 37 + 3), 1'b0);
    chk("idle_thr", thresholds_o, 32'h0);
    chk("idle_flags", {30'd0, valid_o, busy_o}, 32'h0);

    // One window: 5, -3, 100, 7
    step(1'b1, 1'b1, 16'd999, 1'b0);
    chk("enter_busy", {31'd0, busy_o}, 32'd1);
    exp_q.push_back(32'h0064_FFFD);
    step(1'b1, 1'b1, 16'd5, 1'b0);
    step(1'b1, 1'b1, 16'hFFFD, 1'b0);
    step(1'b1, 1'b1, 16'd100, 1'b0);
    chk("one_win_pre_done", {31'd0, window_done_o}, 32'd0);
    step(1'b1, 1'b1, 16'd7, 1'b0);
    chk("one_win_thr", thresholds_o, 32'h0064_FFFD);
    chk("one_win_done", {30'd0, valid_o, window_done_o}, 32'h3);

    // Extremes with an invalid gap
    exp_q.push_back(32'h7FFF_8000);
    step(1'b1, 1'b1, 16'h8000, 1'b0);
    chk("done_one_cycle", {31'd0, window_done_o}, 32'd0);
    step(1'b1, 1'b0, 16'h7FFF, 1'b0);
    step(1'b1, 1'b1, 16'h7FFF, 1'b0);
    step(1'b1, 1'b1, 16'h0000, 1'b0);
    chk("gap_no_early_done", {31'd0, window_done_o}, 32'd0);
    step(1'b1, 1'b1, 16'h0000, 1'b0);
    chk("extreme_thr", thresholds_o, 32'h7FFF_8000);

    // Back-to-back windows 1..8
    exp_q.push_back(32'h0004_0001);
    exp_q.push_back(32'h0008_0005);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, 16'(i), 1'b0);
      if (i == 4) chk("b2b_first", thresholds_o, 32'h0004_0001);
      if (i == 5) chk("b2b_gap_done", {31'd0, window_done_o}, 32'd0);
    end
    chk("b2b_second", thresholds_o, 32'h0008_0005);

    // Abort a partial window, then re-enter
    step(1'b1, 1'b1, 16'd50, 1'b0);
    step(1'b1, 1'b1, 16'd60, 1'b0);
    step(1'b0, 1'b1, 16'd70, 1'b0);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_hold", thresholds_o, 32'h0008_0005);
    step(1'b1, 1'b1, 16'd80, 1'b0);
    exp_q.push_back(32'h000C_0009);
    for (int i = 9; i <= 12; i++) step(1'b1, 1'b1, 16'(i), 1'b0);
    chk("reentry_thr", thresholds_o, 32'h000C_0009);

    // Clear coincident with a final sample
    step(1'b1, 1'b1, 16'd1, 1'b0);
    step(1'b1, 1'b1, 16'd2, 1'b0);
    step(1'b1, 1'b1, 16'd3, 1'b0);
    step(1'b1, 1'b1, 16'd4, 1'b1);
    chk("clear_thr", thresholds_o, 32'h0);
    chk("clear_flags", {29'd0, valid_o, window_done_o, busy_o}, 32'h1);
    exp_q.push_back(32'hFFFF_FFFC);
    step(1'b1, 1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 1'b1, 16'hFFFE, 1'b0);
    step(1'b1, 1'b1, 16'hFFFD, 1'b0);
    step(1'b1, 1'b1, 16'hFFFC, 1'b0);
    chk("neg_thr", thresholds_o, 32'hFFFF_FFFC);

    // Asynchronous reset mid-cycle
    step(1'b1, 1'b1, 16'd10, 1'b0);
    step(1'b1, 1'b1, 16'd20, 1'b0);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("async_rst_thr", thresholds_o, 32'h0);
    chk("async_rst_flags", {29'd0, valid_o, window_done_o, busy_o}, 32'h0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    step(1'b0, 1'b0, 16'd0, 1'b0);

    chk("pending_publishes", 32'(exp_q.size()), 32'd0);
    chk("publish_pulses", 32'(pulses), 32'd6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
